dma_cmd_queue: RTL and testbench

- Memory-mapped front end directly upstream of dma_ctrl.
- The CPU stages SRC/DST/WIDTH registers, then writes CMD to push a descriptor into a small FIFO.
- A dispatch FSM pops descriptors, pulses cmd to dma_ctrl, holds parameters stable until dmaValid, and exposes status, completion count and a blocking fence register.

---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_desc_fifo.sv | 40 ++++
 rtl/dma_cmd_queue.sv | 114 +++++++++++
 tb/tb_dma_cmd_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and register map for the DMA command queue
package dma_pkg;
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_D2S  = 2'b01,
    CMD_S2D  = 2'b10
  } cmd_e;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_WIDTH  = 3'd2;
  localparam logic [2:0] REG_CMD    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_DONE   = 3'd5;
  localparam logic [2:0] REG_FENCE  = 3'd6;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] src;
    logic [31:0] dst;
    logic [9:0]  width;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;
endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: power-of-two descriptor FIFO; push+pop together is legal even when full
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  desc_t       din,
  output desc_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  desc_t mem [DEPTH];
  logic [AW-1:0] wp, rp;

  assign dout  = mem[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;

  // storage, pointers and fill level; a full FIFO may push only because the caller pops in the same edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: MMIO descriptor queue and dispatch FSM in front of dma_ctrl
module dma_cmd_queue
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpuSelect,
  input  logic        cpuWriteEnable,
  input  logic [4:0]  cpuAddr,
  input  logic [31:0] cpuWriteData,
  output logic [31:0] cpuReadData,
  output logic        cpuStall,
  output logic [1:0]  cmd,
  output logic [31:0] srcAddr,
  output logic [31:0] destAddr,
  output logic [9:0]  width,
  input  logic        dmaValid,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] src_q, dst_q;
  logic [9:0] width_q;
  desc_t head, active;
  state_e state;
  logic [CNT_W-1:0] done_count;
  logic [AW:0] count;
  logic [2:0] reg_sel;
  logic err, full, empty, wr, push_req, push, pop, done_inc, done_clr, err_clr, unused;

  assign reg_sel  = cpuAddr[4:2];
  assign unused   = ^cpuAddr[1:0];
  assign wr       = cpuSelect & cpuWriteEnable;
  assign push_req = wr & reg_sel == REG_CMD &
                    (cpuWriteData == {30'd0, CMD_D2S} | cpuWriteData == {30'd0, CMD_S2D});
  assign pop      = state == ST_IDLE & !empty;
  assign push     = push_req & (!full | pop);
  assign busy     = !empty | state != ST_IDLE;
  assign cpuStall = (push_req & full & !pop) |
                    (cpuSelect & !cpuWriteEnable & reg_sel == REG_FENCE & busy);
  assign done_inc = (state == ST_ISSUE & active.width == '0) | (state == ST_WAIT & dmaValid);
  assign done_clr = wr & reg_sel == REG_DONE;
  assign err_clr  = wr & reg_sel == REG_STATUS & cpuWriteData[2];
  assign srcAddr  = active.src;
  assign destAddr = active.dst;
  assign width    = active.width;

  dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({cpuWriteData[1:0], src_q, dst_q, width_q}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // combinational register read-back; write-only and fence offsets read as zero
  always_comb begin
    cpuReadData = '0;
    case (reg_sel)
      REG_SRC:    cpuReadData = src_q;
      REG_DST:    cpuReadData = dst_q;
      REG_WIDTH:  cpuReadData = {22'd0, width_q};
      REG_STATUS: cpuReadData = {24'd0, 4'(count), 1'b0, err, full, busy};
      REG_DONE:   cpuReadData = 32'(done_count);
      default:    cpuReadData = '0;
    endcase
  end

  // staging registers, copied into the FIFO at push time
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      width_q <= '0;
    end else begin
      if (wr & reg_sel == REG_SRC) src_q <= cpuWriteData;
      if (wr & reg_sel == REG_DST) dst_q <= cpuWriteData;
      if (wr & reg_sel == REG_WIDTH) width_q <= cpuWriteData[9:0];
    end

  // dispatch FSM: cmd is registered when the head is popped so it is high only during ISSUE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= ST_IDLE;
      active     <= '0;
      cmd        <= CMD_NONE;
      done_count <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (pop) begin
            active <= head;
            cmd    <= head.width != '0 ? head.kind : CMD_NONE;
            state  <= ST_ISSUE;
          end
        ST_ISSUE: begin
          cmd   <= CMD_NONE;
          state <= active.width == '0 ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT:  if (dmaValid) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      done_count <= done_clr ? '0 : done_count + {{(CNT_W-1){1'b0}}, done_inc};
      err        <= (dmaValid & state != ST_WAIT) | (err & !err_clr);
    end
endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: scoreboard bench with a dma_ctrl responder and a queue-level reference model
module tb_dma_cmd_queue;
  localparam logic [4:0] A_SRC = 5'h00, A_DST = 5'h04, A_WID = 5'h08, A_CMD = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10, A_DONE = 5'h14, A_FENCE = 5'h18;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] s;
    logic [31:0] d;
    logic [9:0]  w;
  } exp_t;

  logic clk = 0, reset = 1, cpuSelect = 0, cpuWriteEnable = 0;
  logic [4:0] cpuAddr = 0;
  logic [31:0] cpuWriteData = 0, cpuReadData, srcAddr, destAddr;
  logic cpuStall, busy;
  logic [1:0] cmd;
  logic [9:0] width;
  logic dv_ctrl = 0, spur = 0;

  exp_t exp_q[$];
  int total = 0, bad = 0, cyc = 0, commit_cyc = 0, last_stall = 0;
  int last_cmd_cyc = -1, valid_cyc = -100, idle_cyc = 0, n_cmd = 0, ctrl_delay = 1;
  bit rnd_delay = 0, b2b = 0;
  logic [31:0] stg_src = 0, stg_dst = 0, r;
  logic [9:0] stg_w = 0;
  logic [15:0] exp_done = 0;

  dma_cmd_queue dut (
    .clk            (clk),
    .reset          (reset),
    .cpuSelect      (cpuSelect),
    .cpuWriteEnable (cpuWriteEnable),
    .cpuAddr        (cpuAddr),
    .cpuWriteData   (cpuWriteData),
    .cpuReadData    (cpuReadData),
    .cpuStall       (cpuStall),
    .cmd            (cmd),
    .srcAddr        (srcAddr),
    .destAddr       (destAddr),
    .width          (width),
    .dmaValid       (dv_ctrl | spur),
    .busy           (busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #500000; $display("FAIL watchdog got=timeout exp=finish"); $fatal(1); end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // one MMIO access; waits out cpuStall, returns read data sampled in the accepting cycle
  task automatic mmio(input logic w, input logic [4:0] a, input logic [31:0] d, output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    cpuSelect = 1; cpuWriteEnable = w; cpuAddr = a; cpuWriteData = d;
    #1;
    while (cpuStall && n < 3000) begin n++; @(negedge clk); #1; end
    if (n >= 3000) chk("stall_timeout", 32'(n), 32'd0);
    rd = cpuReadData;
    last_stall = n;
    @(posedge clk); #1;
    commit_cyc = cyc;
    cpuSelect = 0; cpuWriteEnable = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] junk;
    mmio(1, a, d, junk);
    case (a)
      A_SRC: stg_src = d;
      A_DST: stg_dst = d;
      A_WID: stg_w = d[9:0];
      A_CMD: if (d == 1 || d == 2) begin
        if (stg_w != 0) exp_q.push_back({d[1:0], stg_src, stg_dst, stg_w});
        exp_done++;
      end
      A_DONE: exp_done = 0;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [4:0] a);
    mmio(0, a, 32'd0, r);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    idle_cyc = cyc;
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_cmd(input int n0);
    int k = 0;
    while (n_cmd == n0 && k < 200) begin @(negedge clk); k++; end
    if (n_cmd == n0) chk("cmd_timeout", 32'(n_cmd), 32'(n0 + 1));
  endtask

  // dma_ctrl stand-in: answers each cmd with a dmaValid pulse and checks the parameters held
  initial begin : ctrl
    logic [73:0] cap;
    int d;
    bit ab;
    forever begin
      @(negedge clk);
      if (!reset && cmd != 2'b00) begin
        cap = {srcAddr, destAddr, width};
        d = rnd_delay ? int'($urandom_range(1, 6)) : ctrl_delay;
        ab = 0;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (reset) begin ab = 1; break; end
        end
        if (!ab) begin
          dv_ctrl = 1;
          valid_cyc = cyc;
          total++;
          if ({srcAddr, destAddr, width} !== cap) begin
            bad++;
            $display("FAIL param_hold got=%h exp=%h", {srcAddr, destAddr, width}, cap);
          end
          @(negedge clk);
          dv_ctrl = 0;
        end
      end
    end
  end

  // scoreboard monitor: every cmd pulse must match the oldest expected descriptor
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && cmd != 2'b00) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_unexpected got=%h exp=none", {cmd, srcAddr, destAddr, width});
        end else begin
          e = exp_q.pop_front();
          if ({cmd, srcAddr, destAddr, width} !== e) begin
            bad++;
            $display("FAIL cmd_desc got=%h exp=%h", {cmd, srcAddr, destAddr, width}, e);
          end
        end
        if (b2b) chk("b2b_latency", 32'(cyc), 32'(valid_cyc + 2));
        last_cmd_cyc = cyc;
        n_cmd++;
      end
    end
  end

  initial begin
    int c0, n0, found;
    logic [31:0] v;
    int op;
    repeat (3) @(negedge clk);
    cpuSelect = 1; cpuAddr = A_STAT; #1;
    chk("reset_cmd", 32'(cmd), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_stall", 32'(cpuStall), 0);
    chk("reset_status", cpuReadData, 0);
    cpuSelect = 0;
    @(negedge clk); reset = 0;

    wr(A_SRC, 32'h1000); wr(A_DST, 32'h40);
    rd(A_SRC); chk("rb_src", r, 32'h1000);
    rd(A_DST); chk("rb_dst", r, 32'h40);
    wr(A_WID, 32'hFFFF_FFFF); rd(A_WID); chk("rb_width_mask", r, 32'h3FF);
    wr(A_WID, 8);
    rd(A_CMD); chk("rb_cmd_zero", r, 0);
    ctrl_delay = 20;
    wr(A_CMD, 1); c0 = commit_cyc;
    wait_idle();
    chk("single_cmd_latency", 32'(last_cmd_cyc), 32'(c0 + 1));
    chk("single_busy_drop", 32'(idle_cyc), 32'(valid_cyc + 1));
    rd(A_DONE); chk("single_done", r, 32'(exp_done));

    wr(A_WID, 0); wr(A_CMD, 2); c0 = commit_cyc;
    cpuSelect = 1; cpuWriteEnable = 0; cpuAddr = A_DONE; found = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (found < 0 && cpuReadData[15:0] == exp_done) found = cyc - c0;
    end
    cpuSelect = 0;
    chk("zero_width_done_cycle", 32'(found), 2);

    wr(A_WID, 5); wr(A_SRC, 32'h2000); wr(A_DST, 32'h3000);
    ctrl_delay = 10; n0 = n_cmd;
    wr(A_CMD, 1); wait_cmd(n0);
    wr(A_SRC, 32'hDEAD);
    chk("src_hold_after_rewrite", srcAddr, 32'h2000);
    wr(A_CMD, 2);
    wait_idle();

    ctrl_delay = 30; n0 = n_cmd;
    wr(A_WID, 12); wr(A_CMD, 1); wait_cmd(n0);
    b2b = 1;
    for (int i = 0; i < 4; i++) begin
      wr(A_SRC, $urandom);
      wr(A_CMD, 32'($urandom_range(1, 2)));
    end
    rd(A_STAT); chk("fill_status", r, 32'h43);
    wr(A_SRC, $urandom); wr(A_CMD, 1);
    chk("fill_stalled", 32'(last_stall > 0), 1);
    chk("fill_release_cycle", 32'(commit_cyc), 32'(valid_cyc + 2));
    wait_idle(); b2b = 0;
    rd(A_DONE); chk("fill_done", r, 32'(exp_done));

    ctrl_delay = 5;
    wr(A_CMD, 1); wr(A_CMD, 2);
    rd(A_FENCE);
    chk("fence_read", r, 0);
    chk("fence_stalled", 32'(last_stall > 0), 1);
    chk("fence_release_cycle", 32'(commit_cyc), 32'(valid_cyc + 2));
    @(negedge clk); spur = 1; @(negedge clk); spur = 0;
    rd(A_STAT); chk("err_set", r, 32'h4);
    wr(A_STAT, 32'h4); rd(A_STAT); chk("err_clear", r, 0);
    wr(A_DONE, 32'h1234); rd(A_DONE); chk("done_clear", r, 0);

    rnd_delay = 1;
    for (int i = 0; i < 30; i++) begin
      wr(A_SRC, $urandom); wr(A_DST, $urandom);
      v = $urandom;
      if ($urandom_range(0, 5) == 0) v[9:0] = 0;
      wr(A_WID, v);
      op = int'($urandom_range(0, 9));
      wr(A_CMD, op < 8 ? 32'(op % 2 + 1) : (op == 8 ? 32'd0 : 32'd3));
    end
    wait_idle();
    rd(A_DONE); chk("rand_done", r, 32'(exp_done));
    chk("rand_queue_drained", 32'(exp_q.size()), 0);

    rnd_delay = 0; ctrl_delay = 1000; n0 = n_cmd;
    wr(A_WID, 4); wr(A_CMD, 1); wait_cmd(n0);
    wr(A_CMD, 2); wr(A_CMD, 1);
    @(negedge clk); reset = 1; cpuSelect = 1; cpuWriteEnable = 0; cpuAddr = A_STAT; #1;
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_status", cpuReadData, 0);
    chk("rst_busy", 32'(busy), 0);
    cpuAddr = A_DONE; #1;
    chk("rst_done", cpuReadData, 0);
    exp_q.delete(); exp_done = 0; stg_src = 0; stg_dst = 0; stg_w = 0;
    repeat (2) @(negedge clk);
    reset = 0; cpuSelect = 0;
    repeat (4) @(negedge clk);
    rd(A_STAT); chk("post_rst_status", r, 0);
    rd(A_SRC); chk("post_rst_src", r, 0);
    ctrl_delay = 2;
    wr(A_SRC, 32'h77); wr(A_WID, 3); wr(A_CMD, 1);
    wait_idle();
    rd(A_DONE); chk("post_rst_done", r, 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
